// File: rtl/pixel_plot_sink.sv
// Generic synchronous FIFO with registered occupancy.
// Latency: a push is visible at the head one cycle after the edge that writes it.
// Backpressure: push_rdy drops when full unless a pop happens on the same edge.
module fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 8
) (
    input  logic         core_clk,
    input  logic         arst_n,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    output logic         push_rdy,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;

    assign full     = (count == CW'(DEPTH));
    assign pop_vld  = (count != '0);
    assign push_rdy = !full || pop_rdy;
    assign push     = push_vld && push_rdy;
    assign pop      = pop_rdy && pop_vld;
    assign pop_dat  = mem[rd_ptr];

    always_ff @(posedge core_clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Plot-stream sink: range-checks pixels, linearises (X,Y), buffers, writes framebuffer.
// Latency: request at edge N is popped at N+1; earliest framebuffer transfer at N+2.
// Backpressure: mem_ready stalls the holding register; source is never stalled, losses set overflow.
module pixel_plot_sink #(
    parameter int DEPTH    = 8,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [7:0]  X,
    input  logic [6:0]  Y,
    input  logic [2:0]  COLOUR,
    input  logic        writeEn,
    output logic [14:0] mem_addr,
    output logic [2:0]  mem_data,
    output logic        mem_wren,
    input  logic        mem_ready,
    output logic        full,
    output logic        overflow,
    output logic [7:0]  dropped,
    output logic        idle
);
    localparam logic [7:0] X_LIM = 8'(SCREEN_W);
    localparam logic [6:0] Y_LIM = 7'(SCREEN_H);

    logic        in_range;
    logic [14:0] pix_addr;
    logic        push_vld, push_rdy;
    logic        pop_vld, pop_rdy;
    logic [17:0] pop_dat;
    logic        transfer, load;

    assign in_range = (X < X_LIM) && (Y < Y_LIM);
    // Y*160 as two shifts; the maximum 19199 fits in 15 bits.
    assign pix_addr = {1'b0, Y, 7'b0} + {3'b0, Y, 5'b0} + {7'b0, X};
    assign push_vld = writeEn && in_range;

    assign transfer = mem_wren && mem_ready;
    assign pop_rdy  = !mem_wren || mem_ready;
    assign load     = pop_rdy && pop_vld;
    assign idle     = !pop_vld && !mem_wren;

    fifo #(.W(18), .DEPTH(DEPTH)) u_fifo (
        .core_clk (clock),
        .arst_n   (resetn),
        .push_vld (push_vld),
        .push_dat ({pix_addr, COLOUR}),
        .push_rdy (push_rdy),
        .pop_vld  (pop_vld),
        .pop_rdy  (pop_rdy),
        .pop_dat  (pop_dat),
        .full     (full)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mem_addr <= '0;
            mem_data <= '0;
            mem_wren <= 1'b0;
            overflow <= 1'b0;
            dropped  <= '0;
        end else begin
            if (load) begin
                mem_addr <= pop_dat[17:3];
                mem_data <= pop_dat[2:0];
                mem_wren <= 1'b1;
            end else if (transfer) begin
                mem_wren <= 1'b0;
            end
            if (push_vld && !push_rdy) overflow <= 1'b1;
            if (writeEn && !in_range && dropped != 8'hFF) dropped <= dropped + 8'd1;
        end
    end
endmodule

// File: tb/tb_pixel_plot_sink.sv
// Randomised and directed bench with occupancy-level reference model and write-order scoreboard.
module tb_pixel_plot_sink;
    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  X = '0;
    logic [6:0]  Y = '0;
    logic [2:0]  COLOUR = '0;
    logic        writeEn = 1'b0;
    logic        mem_ready = 1'b0;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_wren, full, overflow, idle;
    logic [7:0]  dropped;

    int checks = 0;
    int errors = 0;

    logic [17:0] exp_q[$];
    int m_cnt;
    bit m_hold_v;
    bit m_over;
    int m_drop;

    pixel_plot_sink #(.DEPTH(DEPTH), .SCREEN_W(160), .SCREEN_H(120)) dut (
        .clock(clock), .resetn(resetn), .X(X), .Y(Y), .COLOUR(COLOUR),
        .writeEn(writeEn), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_wren(mem_wren), .mem_ready(mem_ready), .full(full),
        .overflow(overflow), .dropped(dropped), .idle(idle)
    );

    always #5 clock = ~clock;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_cnt = 0;
        m_hold_v = 0;
        m_over = 0;
        m_drop = 0;
        exp_q.delete();
    endtask

    // Advance the reference model by one clock edge with the given inputs.
    task automatic model_step(bit we, int x, int y, int c, bit rdy);
        bit inr, pop, xfer, acc;
        inr  = (x < 160) && (y < 120);
        pop  = (m_cnt > 0) && (!m_hold_v || rdy);
        xfer = m_hold_v && rdy;
        acc  = 0;
        if (we && !inr && m_drop < 255) m_drop++;
        if (we && inr) begin
            if (m_cnt < DEPTH || pop) begin
                acc = 1;
                exp_q.push_back({15'(y * 160 + x), 3'(c)});
            end else begin
                m_over = 1;
            end
        end
        if (pop) begin
            m_cnt--;
            m_hold_v = 1;
        end else if (xfer) begin
            m_hold_v = 0;
        end
        if (acc) m_cnt++;
    endtask

    task automatic check_state();
        chk("mem_wren", int'(mem_wren), int'(m_hold_v));
        chk("full", int'(full), int'(m_cnt == DEPTH));
        chk("overflow", int'(overflow), int'(m_over));
        chk("dropped", int'(dropped), m_drop);
        chk("idle", int'(idle), int'(m_cnt == 0 && !m_hold_v));
    endtask

    // Called at a falling edge; returns at the next falling edge after checking state.
    task automatic step(bit we, int x, int y, int c, bit rdy);
        writeEn = we;
        X = 8'(x);
        Y = 7'(y);
        COLOUR = 3'(c);
        mem_ready = rdy;
        model_step(we, x, y, c, rdy);
        @(negedge clock);
        check_state();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        writeEn = 1'b0;
        model_clear();
        @(negedge clock);
        resetn = 1'b1;
    endtask

    // Monitor: just before each rising edge, a transfer must match the oldest accepted pixel.
    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clock);
            #4;
            if (resetn && mem_wren && mem_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", int'(mem_addr), int'(e[17:3]));
                    chk("wr_data", int'(mem_data), int'(e[2:0]));
                end
            end
        end
    end

    initial begin
        model_clear();
        @(negedge clock);
        #1;
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_wren", int'(mem_wren), 0);
        chk("rst_idle", int'(idle), 1);
        resetn = 1'b1;

        // 1: single pixel latency and address
        step(1, 10, 5, 2, 1);
        chk("t1_wren_n", int'(mem_wren), 0);
        step(0, 0, 0, 0, 1);
        chk("t1_wren", int'(mem_wren), 1);
        chk("t1_addr", int'(mem_addr), 810);
        chk("t1_data", int'(mem_data), 2);
        step(0, 0, 0, 0, 1);
        chk("t1_wren_off", int'(mem_wren), 0);
        chk("t1_idle", int'(idle), 1);

        // 2: out-of-range drops and saturation
        step(1, 160, 0, 1, 1);
        step(1, 0, 120, 1, 1);
        step(1, 200, 127, 1, 1);
        chk("t2_dropped3", int'(dropped), 3);
        for (int i = 0; i < 300; i++)
            step(1, $urandom_range(160, 255), $urandom_range(0, 127), 0, 1);
        chk("t2_dropped_sat", int'(dropped), 255);

        // 3: stall fill, overflow, ordered drain
        do_reset();
        for (int i = 0; i < 10; i++) step(1, i, 1, i, 0);
        chk("t3_hold_addr", int'(mem_addr), 160);
        chk("t3_full", int'(full), 1);
        chk("t3_overflow", int'(overflow), 1);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 1);
        chk("t3_wren_done", int'(mem_wren), 0);
        chk("t3_full_done", int'(full), 0);

        // 4: push on the transfer edge while full
        do_reset();
        for (int i = 0; i < 9; i++) step(1, 20 + i, 3, 1, 0);
        chk("t4_full", int'(full), 1);
        step(1, 50, 2, 5, 1);
        chk("t4_full_kept", int'(full), 1);
        chk("t4_overflow", int'(overflow), 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1);

        // 5: corner addresses
        step(1, 159, 119, 7, 1);
        step(0, 0, 0, 0, 0);
        chk("t5_addr_max", int'(mem_addr), 19199);
        chk("t5_data_max", int'(mem_data), 7);
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("t5_addr_zero", int'(mem_addr), 0);
        step(0, 0, 0, 0, 1);

        // 6: asynchronous reset with pixels in flight
        for (int i = 0; i < 3; i++) step(1, 40 + i, 7, 3, 0);
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_wren", int'(mem_wren), 0);
        chk("t6_addr", int'(mem_addr), 0);
        chk("t6_data", int'(mem_data), 0);
        chk("t6_idle", int'(idle), 1);
        chk("t6_full", int'(full), 0);
        model_clear();
        writeEn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);

        // Randomised traffic
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 175), $urandom_range(0, 127),
                 $urandom_range(0, 7), $urandom_range(0, 9) < 6);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1);
        chk("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
